// File: rtl/fft32_tw_sched.sv
// rtl/fft32_tw_sched.sv - advance/twiddle scheduler for a 32-point radix-2 SDF FFT.
// Define FFT32_TW_SCHED_FLUSH_EN to add the FLUSH state that auto-drains the pipeline.
module fft32_tw_sched #(
  parameter int FLUSH_CYC = 31
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_adv,
  output logic [4:0] o_bf_sel,
  output logic [3:0] o_tw_addr_s0,
  output logic [3:0] o_tw_addr_s1,
  output logic [3:0] o_tw_addr_s2,
  output logic [3:0] o_tw_addr_s3,
  output logic       o_out_valid,
  output logic [4:0] o_out_idx
);

  localparam int WW = $clog2(FLUSH_CYC + 1);
  localparam logic [WW-1:0] WARM_MAX = WW'(FLUSH_CYC);

`ifdef FFT32_TW_SCHED_FLUSH_EN
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t          state_q;
  logic [4:0]      cnt_q;
  logic [4:0]      out_cnt_q;
  logic [WW-1:0]   warm_q;
  logic [5:0]      pend_q;
  logic [5:0]      pend_d;
  logic            flush_now;
  logic            accept;
  logic            drain_done;

`ifdef FFT32_TW_SCHED_FLUSH_EN
  // A frame boundary with no new input and samples in flight starts draining in that same cycle.
  assign flush_now = (state_q == FLUSH) ||
                     ((state_q == RUN) && (cnt_q == 5'd0) && !i_in_valid && (pend_q != 6'd0));
`else
  assign flush_now = 1'b0;
`endif

  assign o_in_ready  = ~flush_now;
  assign o_adv       = i_in_valid | flush_now;
  assign accept      = i_in_valid & ~flush_now;
  assign o_out_valid = o_adv && (warm_q == WARM_MAX) && (pend_q != 6'd0);
  assign drain_done  = flush_now && (pend_d == 6'd0);

  always_comb begin
    pend_d = pend_q;
    if (accept && !o_out_valid) begin
      pend_d = pend_q + 6'd1;
    end else if (!accept && o_out_valid) begin
      pend_d = pend_q - 6'd1;
    end
  end

  assign o_bf_sel     = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3], cnt_q[4]};
  assign o_tw_addr_s0 = cnt_q[3:0];
  assign o_tw_addr_s1 = {cnt_q[2:0], 1'b0};
  assign o_tw_addr_s2 = {cnt_q[1:0], 2'b00};
  assign o_tw_addr_s3 = {cnt_q[0], 3'b000};
  assign o_out_idx    = {out_cnt_q[0], out_cnt_q[1], out_cnt_q[2], out_cnt_q[3], out_cnt_q[4]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      warm_q    <= '0;
      pend_q    <= 6'd0;
      out_cnt_q <= 5'd0;
    end else begin
      pend_q <= pend_d;
      if (o_adv) begin
        cnt_q <= cnt_q + 5'd1;
        if (warm_q != WARM_MAX) begin
          warm_q <= warm_q + WW'(1);
        end
      end
      if (o_out_valid) begin
        out_cnt_q <= out_cnt_q + 5'd1;
      end
      case (state_q)
        IDLE: if (accept) state_q <= RUN;
`ifdef FFT32_TW_SCHED_FLUSH_EN
        RUN:  if (flush_now) state_q <= FLUSH;
`endif
        default: ;
      endcase
      // Pipeline empty again: realign so the next frame starts at W0 with a cold pipeline.
      if (drain_done) begin
        state_q   <= IDLE;
        cnt_q     <= 5'd0;
        warm_q    <= '0;
        out_cnt_q <= 5'd0;
      end
    end
  end

endmodule
